// File: rtl/qspi_psram_model_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qspi_psram_model_pkg : state encodings, default command codes, phase lengths
// Revision 1.0
// ----------------------------------------------------------------------------
package qspi_psram_model_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CMD   = 3'd1;
    localparam state_t ST_ADDR  = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_RDATA = 3'd4;
    localparam state_t ST_WDATA = 3'd5;
    localparam state_t ST_SKIP  = 3'd6;

    localparam logic [7:0] DEF_CMD_RD     = 8'hEB;
    localparam logic [7:0] DEF_CMD_WR     = 8'h38;
    localparam logic [7:0] DEF_CMD_QPI_EN = 8'h35;
    localparam logic [7:0] DEF_CMD_QPI_EX = 8'hF5;

    localparam int         ADDR_NIBBLES = 6;
    localparam logic [7:0] ADDR_LAST    = 8'(ADDR_NIBBLES - 1);

endpackage
`default_nettype wire

// File: rtl/qspi_psram_model_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qspi_psram_model_if : QSPI pin bundle between memory controller and PSRAM
// Revision 1.0
// ----------------------------------------------------------------------------
interface qspi_psram_model_if;

    logic       qspi_sck;
    logic       qspi_cs_n;
    logic [3:0] qspi_sio_i;
    logic [3:0] qspi_sio_o;
    logic       qspi_sio_oe;

    modport master (
        output qspi_sck,
        output qspi_cs_n,
        output qspi_sio_i,
        input  qspi_sio_o,
        input  qspi_sio_oe
    );

    modport slave (
        input  qspi_sck,
        input  qspi_cs_n,
        input  qspi_sio_i,
        output qspi_sio_o,
        output qspi_sio_oe
    );

endinterface
`default_nettype wire

// File: rtl/qspi_nram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qspi_nram : 2^ADR_W x 4 1r1w RAM, registered read address, synchronous write
// Revision 1.0
// ----------------------------------------------------------------------------
module qspi_nram #(
    parameter int ADR_W = 17
) (
    input  wire              clk,
    input  wire              we,
    input  wire [ADR_W-1:0]  waddr,
    input  wire [3:0]        wdata,
    input  wire              re,
    input  wire [ADR_W-1:0]  raddr,
    output logic [3:0]       rdata
);

    logic [3:0]       r_mem [2**ADR_W];
    logic [ADR_W-1:0] r_raddr;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_raddr <= raddr;
        end
    end

    assign rdata = r_mem[r_raddr];

endmodule
`default_nettype wire

// File: rtl/qspi_psram_model.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qspi_psram_model : SPI/QPI PSRAM device model over an oversampled SCK
// Revision 1.0
// ----------------------------------------------------------------------------
module qspi_psram_model
    import qspi_psram_model_pkg::*;
#(
    parameter int         ADR_W      = 17,
    parameter int         WAIT_CYC   = 6,
    parameter logic [7:0] CMD_RD     = DEF_CMD_RD,
    parameter logic [7:0] CMD_WR     = DEF_CMD_WR,
    parameter logic [7:0] CMD_QPI_EN = DEF_CMD_QPI_EN,
    parameter logic [7:0] CMD_QPI_EX = DEF_CMD_QPI_EX
) (
    input  wire                clk,
    input  wire                rst_n,
    qspi_psram_model_if.slave  bus,
    output logic               qpi_mode,
    output logic               busy
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYC - 1);
    localparam logic [ADR_W-1:0] NP_ONE = {{(ADR_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic             r_sck_q;
    logic             w_rise, w_fall;
    logic [7:0]       r_cnt;
    logic [7:0]       r_cmd, w_cmd_shift;
    logic [ADR_W-2:0] r_adr, w_adr_shift;
    logic [ADR_W-1:0] r_np, w_np_start, w_ram_raddr;
    logic             w_cmd_done, w_adr_done, w_wait_done;
    logic             r_is_rd, r_pend_vld, r_pend_qpi, r_rd_pend;
    logic             r_qpi, r_sio_oe;
    logic [3:0]       r_sio_o, w_ram_rdata;
    logic             w_ram_we, w_ram_re;

    // SCK edges only count while the chip is selected
    assign w_rise = bus.qspi_sck & ~r_sck_q & ~bus.qspi_cs_n;
    assign w_fall = ~bus.qspi_sck & r_sck_q & ~bus.qspi_cs_n;

    assign w_cmd_shift = r_qpi ? ((r_cmd << 4) | {4'h0, bus.qspi_sio_i})
                               : ((r_cmd << 1) | {7'h00, bus.qspi_sio_i[0]});
    assign w_adr_shift = (r_adr << 4) | (ADR_W-1)'(bus.qspi_sio_i);
    assign w_np_start  = {w_adr_shift, 1'b0};

    assign w_cmd_done  = w_rise && (r_cnt == (r_qpi ? 8'd1 : 8'd7));
    assign w_adr_done  = w_rise && (r_cnt == ADDR_LAST);
    assign w_wait_done = w_rise && (r_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.qspi_cs_n) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_CMD;
                ST_CMD: begin
                    if (w_cmd_done) begin
                        if (w_cmd_shift == CMD_RD || w_cmd_shift == CMD_WR) begin
                            w_state_nxt = ST_ADDR;
                        end else begin
                            w_state_nxt = ST_SKIP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_adr_done) begin
                        if (!r_is_rd) begin
                            w_state_nxt = ST_WDATA;
                        end else if (WAIT_CYC == 0) begin
                            w_state_nxt = ST_RDATA;
                        end else begin
                            w_state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: if (w_wait_done) w_state_nxt = ST_RDATA;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // A read is issued on the rise that enters RDATA and on every RDATA rise
    always_comb begin
        busy        = (r_state != ST_IDLE);
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_raddr = r_np;
        case (r_state)
            ST_ADDR: begin
                if (w_adr_done && r_is_rd && WAIT_CYC == 0) begin
                    w_ram_re    = 1'b1;
                    w_ram_raddr = w_np_start;
                end
            end
            ST_WAIT:  w_ram_re = w_wait_done;
            ST_RDATA: w_ram_re = w_rise;
            ST_WDATA: w_ram_we = w_rise;
            default: begin
                w_ram_we = 1'b0;
                w_ram_re = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_q    <= 1'b0;
            r_cnt      <= 8'd0;
            r_cmd      <= 8'd0;
            r_adr      <= '0;
            r_np       <= '0;
            r_is_rd    <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_qpi <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_qpi      <= 1'b0;
            r_sio_o    <= 4'h0;
            r_sio_oe   <= 1'b0;
        end else begin
            r_sck_q <= bus.qspi_sck;

            if (w_state_nxt != r_state) begin
                r_cnt <= 8'd0;
            end else if (w_rise) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (r_state == ST_CMD && w_rise) begin
                r_cmd <= w_cmd_shift;
            end
            if (r_state == ST_CMD && w_cmd_done) begin
                r_is_rd <= (w_cmd_shift == CMD_RD);
                if (w_cmd_shift == CMD_QPI_EN || w_cmd_shift == CMD_QPI_EX) begin
                    r_pend_vld <= 1'b1;
                    r_pend_qpi <= (w_cmd_shift == CMD_QPI_EN);
                end
            end

            if (r_state == ST_ADDR && w_rise) begin
                r_adr <= w_adr_shift;
            end

            if (r_state == ST_ADDR && w_adr_done) begin
                r_np <= w_ram_re ? (w_np_start + NP_ONE) : w_np_start;
            end else if (w_ram_re || w_ram_we) begin
                r_np <= r_np + NP_ONE;
            end

            // Deselect ends the transaction and commits any mode change
            if (bus.qspi_cs_n) begin
                if (r_pend_vld) begin
                    r_qpi <= r_pend_qpi;
                end
                r_pend_vld <= 1'b0;
                r_rd_pend  <= 1'b0;
                r_sio_oe   <= 1'b0;
            end else if (w_ram_re) begin
                r_rd_pend <= 1'b1;
            end else if (w_fall && r_rd_pend) begin
                r_sio_o   <= w_ram_rdata;
                r_sio_oe  <= 1'b1;
                r_rd_pend <= 1'b0;
            end
        end
    end

    assign qpi_mode        = r_qpi;
    assign bus.qspi_sio_o  = r_sio_o;
    assign bus.qspi_sio_oe = r_sio_oe;

    qspi_nram #(
        .ADR_W (ADR_W)
    ) u_nram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (r_np),
        .wdata (bus.qspi_sio_i),
        .re    (w_ram_re),
        .raddr (w_ram_raddr),
        .rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_qspi_psram_model.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_qspi_psram_model : scoreboard bench driving SPI/QPI transactions
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_qspi_psram_model;
    import qspi_psram_model_pkg::*;

    localparam int ADR_W    = 17;
    localparam int WAIT_CYC = 6;
    localparam int NP_MASK  = (1 << ADR_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic qpi_mode;
    logic busy;
    logic tb_qpi;
    int   checks   = 0;
    int   failures = 0;

    logic [3:0] mem_model [int];
    logic [3:0] exp_q [$];

    qspi_psram_model_if bus ();

    qspi_psram_model #(
        .ADR_W    (ADR_W),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .qpi_mode (qpi_mode),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic int byte_to_np(input logic [23:0] adr);
        return (int'(adr) % (1 << (ADR_W - 1))) * 2;
    endfunction

    function automatic void model_write(input logic [23:0] adr, input int n, input logic [31:0] data);
        int np = byte_to_np(adr);
        for (int k = 0; k < n; k++) begin
            mem_model[np] = data[31-4*k -: 4];
            np = (np + 1) & NP_MASK;
        end
    endfunction

    function automatic void push_expected(input logic [23:0] adr, input int n);
        int np = byte_to_np(adr);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(mem_model[np]);
            np = (np + 1) & NP_MASK;
        end
    endfunction

    task automatic sck_cycle(input logic [3:0] d, output logic [3:0] o, output logic oe);
        bus.qspi_sio_i = d;
        repeat (3) @(negedge clk);
        bus.qspi_sck = 1'b1;
        repeat (3) @(negedge clk);
        bus.qspi_sck = 1'b0;
        repeat (2) @(negedge clk);
        o  = bus.qspi_sio_o;
        oe = bus.qspi_sio_oe;
    endtask

    task automatic cs_low();
        bus.qspi_cs_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_high();
        bus.qspi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        logic [3:0] o;
        logic       oe;
        if (tb_qpi) begin
            sck_cycle(c[7:4], o, oe);
            sck_cycle(c[3:0], o, oe);
        end else begin
            for (int i = 7; i >= 0; i--) sck_cycle({3'b000, c[i]}, o, oe);
        end
    endtask

    task automatic send_addr(input logic [23:0] adr);
        logic [3:0] o;
        logic       oe;
        for (int i = 5; i >= 0; i--) sck_cycle(adr[4*i +: 4], o, oe);
    endtask

    task automatic drive_write(input logic [23:0] adr, input int n, input logic [31:0] data);
        logic [3:0] o;
        logic       oe;
        cs_low();
        send_cmd(DEF_CMD_WR);
        send_addr(adr);
        for (int k = 0; k < n; k++) sck_cycle(data[31-4*k -: 4], o, oe);
        cs_high();
    endtask

    // Captures sio after each fall; oe_pre is the fall just before the first data nibble
    task automatic drive_read(input logic [23:0] adr, input int n,
                              output logic [31:0] got, output logic [7:0] oe_mask,
                              output logic oe_pre);
        logic [3:0] o;
        logic       oe;
        logic [3:0] d;
        got     = '0;
        oe_mask = '0;
        oe_pre  = 1'b1;
        cs_low();
        send_cmd(DEF_CMD_RD);
        for (int i = 0; i < 6 + WAIT_CYC + n - 1; i++) begin
            d = (i < 6) ? adr[4*(5-i) +: 4] : 4'h0;
            sck_cycle(d, o, oe);
            if (i == 6 + WAIT_CYC - 2) oe_pre = oe;
            if (i >= 6 + WAIT_CYC - 1) begin
                got[4*(i-(5+WAIT_CYC)) +: 4] = o;
                oe_mask[i-(5+WAIT_CYC)]      = oe;
            end
        end
        cs_high();
    endtask

    task automatic test_reset();
        checks++; if (bus.qspi_sio_o !== 4'h0) begin failures++; $display("FAIL reset_sio_o got=%h exp=0", bus.qspi_sio_o); end
        checks++; if (bus.qspi_sio_oe !== 1'b0) begin failures++; $display("FAIL reset_sio_oe got=%b exp=0", bus.qspi_sio_oe); end
        checks++; if (qpi_mode !== 1'b0) begin failures++; $display("FAIL reset_qpi_mode got=%b exp=0", qpi_mode); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_spi_write_read();
        logic [31:0] got;
        logic [7:0]  oem;
        logic        pre;
        logic [3:0]  e;
        cs_low();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_in_txn got=%b exp=1", busy); end
        cs_high();
        model_write(24'h000010, 4, 32'hA53C_0000);
        drive_write(24'h000010, 4, 32'hA53C_0000);
        push_expected(24'h000010, 4);
        drive_read(24'h000010, 4, got, oem, pre);
        checks++; if (pre !== 1'b0) begin failures++; $display("FAIL spi_rd_latency oe_before_first=%b exp=0", pre); end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++; if (got[4*k +: 4] !== e) begin failures++; $display("FAIL spi_rd_data[%0d] got=%h exp=%h", k, got[4*k +: 4], e); end
            checks++; if (oem[k] !== 1'b1) begin failures++; $display("FAIL spi_rd_oe[%0d] got=%b exp=1", k, oem[k]); end
        end
    endtask

    task automatic test_qpi();
        logic [31:0] got;
        logic [7:0]  oem;
        logic        pre;
        logic [3:0]  e;
        cs_low();
        send_cmd(DEF_CMD_QPI_EN);
        checks++; if (qpi_mode !== 1'b0) begin failures++; $display("FAIL qpi_en_pending got=%b exp=0", qpi_mode); end
        bus.qspi_cs_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (qpi_mode !== 1'b1) begin failures++; $display("FAIL qpi_en_commit got=%b exp=1", qpi_mode); end
        repeat (3) @(negedge clk);
        tb_qpi = 1'b1;
        push_expected(24'h000010, 4);
        drive_read(24'h000010, 4, got, oem, pre);
        checks++; if (pre !== 1'b0) begin failures++; $display("FAIL qpi_rd_latency oe_before_first=%b exp=0", pre); end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++; if (got[4*k +: 4] !== e) begin failures++; $display("FAIL qpi_rd_data[%0d] got=%h exp=%h", k, got[4*k +: 4], e); end
            checks++; if (oem[k] !== 1'b1) begin failures++; $display("FAIL qpi_rd_oe[%0d] got=%b exp=1", k, oem[k]); end
        end
        cs_low();
        send_cmd(DEF_CMD_QPI_EX);
        checks++; if (qpi_mode !== 1'b1) begin failures++; $display("FAIL qpi_ex_pending got=%b exp=1", qpi_mode); end
        bus.qspi_cs_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (qpi_mode !== 1'b0) begin failures++; $display("FAIL qpi_ex_commit got=%b exp=0", qpi_mode); end
        repeat (3) @(negedge clk);
        tb_qpi = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        logic [7:0]  oem;
        logic        pre;
        logic [3:0]  e;
        model_write(24'h00FFFF, 4, 32'h1234_0000);
        drive_write(24'h00FFFF, 4, 32'h1234_0000);
        push_expected(24'h00FFFF, 4);
        drive_read(24'h00FFFF, 4, got, oem, pre);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++; if (got[4*k +: 4] !== e) begin failures++; $display("FAIL wrap_rd_data[%0d] got=%h exp=%h", k, got[4*k +: 4], e); end
        end
        push_expected(24'h000000, 2);
        drive_read(24'h000000, 2, got, oem, pre);
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            checks++; if (got[4*k +: 4] !== e) begin failures++; $display("FAIL wrap_low_data[%0d] got=%h exp=%h", k, got[4*k +: 4], e); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] got;
        logic [7:0]  oem;
        logic        pre;
        logic [3:0]  e;
        logic [3:0]  o;
        logic        oe;
        cs_low();
        send_cmd(DEF_CMD_WR);
        for (int i = 0; i < 3; i++) sck_cycle(4'h0, o, oe);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
        bus.qspi_cs_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy_after got=%b exp=0", busy); end
        checks++; if (bus.qspi_sio_oe !== 1'b0) begin failures++; $display("FAIL abort_oe_after got=%b exp=0", bus.qspi_sio_oe); end
        repeat (3) @(negedge clk);
        push_expected(24'h000010, 4);
        drive_read(24'h000010, 4, got, oem, pre);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++; if (got[4*k +: 4] !== e) begin failures++; $display("FAIL abort_next_rd[%0d] got=%h exp=%h", k, got[4*k +: 4], e); end
        end
    endtask

    task automatic test_unknown();
        logic [31:0] got;
        logic [7:0]  oem;
        logic        pre;
        logic [3:0]  e;
        logic [3:0]  o;
        logic        oe;
        logic        any_oe;
        any_oe = 1'b0;
        cs_low();
        send_cmd(8'h9F);
        for (int i = 0; i < 8; i++) begin
            sck_cycle(4'hF, o, oe);
            any_oe = any_oe | oe;
        end
        checks++; if (any_oe !== 1'b0) begin failures++; $display("FAIL unknown_cmd_oe got=%b exp=0", any_oe); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL unknown_cmd_busy got=%b exp=1", busy); end
        cs_high();
        push_expected(24'h000010, 4);
        drive_read(24'h000010, 4, got, oem, pre);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++; if (got[4*k +: 4] !== e) begin failures++; $display("FAIL unknown_next_rd[%0d] got=%h exp=%h", k, got[4*k +: 4], e); end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] got;
        logic [7:0]  oem;
        logic        pre;
        logic [3:0]  e;
        logic [3:0]  o;
        logic        oe;
        cs_low();
        send_cmd(DEF_CMD_QPI_EN);
        cs_high();
        tb_qpi = 1'b1;
        cs_low();
        send_cmd(DEF_CMD_RD);
        send_addr(24'h000010);
        for (int i = 0; i < WAIT_CYC; i++) sck_cycle(4'h0, o, oe);
        checks++; if (oe !== 1'b1) begin failures++; $display("FAIL midread_oe_before_rst got=%b exp=1", oe); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.qspi_sio_oe !== 1'b0) begin failures++; $display("FAIL midread_async_oe got=%b exp=0", bus.qspi_sio_oe); end
        checks++; if (qpi_mode !== 1'b0) begin failures++; $display("FAIL midread_async_qpi got=%b exp=0", qpi_mode); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midread_async_busy got=%b exp=0", busy); end
        bus.qspi_cs_n = 1'b1;
        tb_qpi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push_expected(24'h000010, 4);
        drive_read(24'h000010, 4, got, oem, pre);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++; if (got[4*k +: 4] !== e) begin failures++; $display("FAIL after_rst_rd[%0d] got=%h exp=%h", k, got[4*k +: 4], e); end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        tb_qpi         = 1'b0;
        bus.qspi_sck   = 1'b0;
        bus.qspi_cs_n  = 1'b1;
        bus.qspi_sio_i = 4'h0;
        repeat (5) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_spi_write_read();
        test_qpi();
        test_wrap();
        test_abort();
        test_unknown();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
